// File: rtl/branch_rs_scheduler.sv
// Reservation station and issue scheduler for the branch execution unit.
// Holds dispatched branch/jump ops and snoops the CDB for missing operands.
// Each cycle it issues the oldest entry whose operands are both ready.
// Ages form a dense 0..occupancy-1 ordering, so the entry with the smallest
// age is always the oldest one in the station.
module branch_rs_scheduler #(
  parameter int RS_SIZE = 4,
  parameter int XLEN    = 32,
  parameter int PRF_LEN = 6,
  parameter int ROB_LEN = 5,
  parameter int PAY_W   = 96
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         dispatch_valid,
  input  logic                         dispatch_opa_ready,
  input  logic [PRF_LEN-1:0]           dispatch_opa_preg,
  input  logic [XLEN-1:0]              dispatch_opa_value,
  input  logic                         dispatch_opb_ready,
  input  logic [PRF_LEN-1:0]           dispatch_opb_preg,
  input  logic [XLEN-1:0]              dispatch_opb_value,
  input  logic [PRF_LEN-1:0]           dispatch_dest_preg,
  input  logic [ROB_LEN-1:0]           dispatch_rob_idx,
  input  logic [PAY_W-1:0]             dispatch_payload,
  input  logic                         cdb_valid,
  input  logic [PRF_LEN-1:0]           cdb_preg,
  input  logic [XLEN-1:0]              cdb_value,
  input  logic                         fu_busy,
  input  logic                         flush,
  output logic                         rs_full,
  output logic [$clog2(RS_SIZE):0]     occupancy,
  output logic                         issue_valid,
  output logic [XLEN-1:0]              issue_opa_value,
  output logic [XLEN-1:0]              issue_opb_value,
  output logic [PRF_LEN-1:0]           issue_dest_preg,
  output logic [ROB_LEN-1:0]           issue_rob_idx,
  output logic [PAY_W-1:0]             issue_payload
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int OCC_W = IDX_W + 1;

  // Entry control state (reset) and entry data state (no reset needed).
  logic [RS_SIZE-1:0] ent_valid;
  logic [RS_SIZE-1:0] opa_rdy;
  logic [RS_SIZE-1:0] opb_rdy;
  logic [IDX_W-1:0]   age     [RS_SIZE];
  logic [PRF_LEN-1:0] opa_tag [RS_SIZE];
  logic [PRF_LEN-1:0] opb_tag [RS_SIZE];
  logic [XLEN-1:0]    opa_val [RS_SIZE];
  logic [XLEN-1:0]    opb_val [RS_SIZE];
  logic [PRF_LEN-1:0] dest    [RS_SIZE];
  logic [ROB_LEN-1:0] rob     [RS_SIZE];
  logic [PAY_W-1:0]   payload [RS_SIZE];

  logic [RS_SIZE-1:0] opa_wake;
  logic [RS_SIZE-1:0] opb_wake;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   sel_age;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               issue_fire;
  logic               dispatch_fire;
  logic               disp_opa_rdy;
  logic               disp_opb_rdy;
  logic [XLEN-1:0]    disp_opa_val;
  logic [XLEN-1:0]    disp_opb_val;
  logic [IDX_W-1:0]   disp_age;
  logic [OCC_W-1:0]   occ_next;

  // CDB tag match for every waiting operand already in the station.
  always_comb begin
    opa_wake = '0;
    opb_wake = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      opa_wake[i] = cdb_valid && ent_valid[i] && !opa_rdy[i] && (opa_tag[i] == cdb_preg);
      opb_wake[i] = cdb_valid && ent_valid[i] && !opb_rdy[i] && (opb_tag[i] == cdb_preg);
    end
  end

  // Oldest-ready select over registered state.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_valid[i] && opa_rdy[i] && opb_rdy[i] && (!sel_found || (age[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  // Lowest-index free slot for the incoming op (scan high to low so low wins).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Fire decisions, dispatch/CDB bypass and next occupancy.
  always_comb begin
    issue_fire    = sel_found && !fu_busy && !flush;
    dispatch_fire = dispatch_valid && !rs_full && !flush && free_found;
    disp_opa_rdy  = dispatch_opa_ready || (cdb_valid && (cdb_preg == dispatch_opa_preg));
    disp_opb_rdy  = dispatch_opb_ready || (cdb_valid && (cdb_preg == dispatch_opb_preg));
    disp_opa_val  = dispatch_opa_ready ? dispatch_opa_value : cdb_value;
    disp_opb_val  = dispatch_opb_ready ? dispatch_opb_value : cdb_value;
    disp_age      = IDX_W'(occupancy - OCC_W'(issue_fire));
    occ_next      = occupancy + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
  end

  // Control state: validity, readiness, ages, counts; flush clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid   <= '0;
      opa_rdy     <= '0;
      opb_rdy     <= '0;
      occupancy   <= '0;
      rs_full     <= 1'b0;
      issue_valid <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else if (flush) begin
      ent_valid   <= '0;
      occupancy   <= '0;
      rs_full     <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (opa_wake[i]) opa_rdy[i] <= 1'b1;
        if (opb_wake[i]) opb_rdy[i] <= 1'b1;
        if (issue_fire && ent_valid[i] && (age[i] > sel_age)) age[i] <= age[i] - IDX_W'(1);
        if (issue_fire && (sel_idx == IDX_W'(i))) ent_valid[i] <= 1'b0;
        if (dispatch_fire && (free_idx == IDX_W'(i))) begin
          ent_valid[i] <= 1'b1;
          opa_rdy[i]   <= disp_opa_rdy;
          opb_rdy[i]   <= disp_opb_rdy;
          age[i]       <= disp_age;
        end
      end
      occupancy   <= occ_next;
      rs_full     <= (occ_next == OCC_W'(RS_SIZE));
      issue_valid <= issue_fire;
    end
  end

  // Entry data: operand capture on wakeup, full load on dispatch.
  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (opa_wake[i]) opa_val[i] <= cdb_value;
      if (opb_wake[i]) opb_val[i] <= cdb_value;
      if (dispatch_fire && (free_idx == IDX_W'(i))) begin
        opa_tag[i] <= dispatch_opa_preg;
        opb_tag[i] <= dispatch_opb_preg;
        opa_val[i] <= disp_opa_val;
        opb_val[i] <= disp_opb_val;
        dest[i]    <= dispatch_dest_preg;
        rob[i]     <= dispatch_rob_idx;
        payload[i] <= dispatch_payload;
      end
    end
  end

  // Issue packet: loads the selected entry, otherwise holds its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_opa_value <= '0;
      issue_opb_value <= '0;
      issue_dest_preg <= '0;
      issue_rob_idx   <= '0;
      issue_payload   <= '0;
    end else if (issue_fire) begin
      issue_opa_value <= opa_val[sel_idx];
      issue_opb_value <= opb_val[sel_idx];
      issue_dest_preg <= dest[sel_idx];
      issue_rob_idx   <= rob[sel_idx];
      issue_payload   <= payload[sel_idx];
    end
  end

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Directed bench for branch_rs_scheduler with an in-order issue scoreboard.
module tb_branch_rs_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_valid;
  logic        dispatch_opa_ready;
  logic [5:0]  dispatch_opa_preg;
  logic [31:0] dispatch_opa_value;
  logic        dispatch_opb_ready;
  logic [5:0]  dispatch_opb_preg;
  logic [31:0] dispatch_opb_value;
  logic [5:0]  dispatch_dest_preg;
  logic [4:0]  dispatch_rob_idx;
  logic [95:0] dispatch_payload;
  logic        cdb_valid;
  logic [5:0]  cdb_preg;
  logic [31:0] cdb_value;
  logic        fu_busy;
  logic        flush;
  logic        rs_full;
  logic [2:0]  occupancy;
  logic        issue_valid;
  logic [31:0] issue_opa_value;
  logic [31:0] issue_opb_value;
  logic [5:0]  issue_dest_preg;
  logic [4:0]  issue_rob_idx;
  logic [95:0] issue_payload;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [5:0]  dest;
    logic [4:0]  rob;
    logic [95:0] pay;
  } pkt_t;

  pkt_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  branch_rs_scheduler dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid),
    .dispatch_opa_ready(dispatch_opa_ready), .dispatch_opa_preg(dispatch_opa_preg),
    .dispatch_opa_value(dispatch_opa_value),
    .dispatch_opb_ready(dispatch_opb_ready), .dispatch_opb_preg(dispatch_opb_preg),
    .dispatch_opb_value(dispatch_opb_value),
    .dispatch_dest_preg(dispatch_dest_preg), .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_payload(dispatch_payload),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_value(cdb_value),
    .fu_busy(fu_busy), .flush(flush),
    .rs_full(rs_full), .occupancy(occupancy),
    .issue_valid(issue_valid),
    .issue_opa_value(issue_opa_value), .issue_opb_value(issue_opb_value),
    .issue_dest_preg(issue_dest_preg), .issue_rob_idx(issue_rob_idx),
    .issue_payload(issue_payload)
  );

  always #5 clock = ~clock;

  function automatic logic [95:0] mkpay(input logic [4:0] r, input logic [5:0] d);
    return {27'h0, r, 32'hCAFE_0000, 26'h0, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] d, input logic [4:0] r);
    pkt_t p;
    p.opa = a; p.opb = b; p.dest = d; p.rob = r; p.pay = mkpay(r, d);
    exp_q.push_back(p);
  endtask

  // One clock edge; outputs sampled 1 time unit later, any issue popped and checked.
  task automatic step();
    pkt_t p;
    @(posedge clock);
    #1;
    if (issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_rob", {123'h0, issue_rob_idx}, 128'h7f);
      end else begin
        p = exp_q.pop_front();
        chk("issue_rob",  issue_rob_idx,   p.rob);
        chk("issue_opa",  issue_opa_value, p.opa);
        chk("issue_opb",  issue_opb_value, p.opb);
        chk("issue_dest", issue_dest_preg, p.dest);
        chk("issue_pay",  issue_payload,   p.pay);
      end
    end
  endtask

  task automatic set_op(input logic ar, input logic [5:0] at, input logic [31:0] av,
                        input logic br, input logic [5:0] bt, input logic [31:0] bv,
                        input logic [5:0] d, input logic [4:0] r);
    dispatch_valid = 1'b1;
    dispatch_opa_ready = ar; dispatch_opa_preg = at; dispatch_opa_value = av;
    dispatch_opb_ready = br; dispatch_opb_preg = bt; dispatch_opb_value = bv;
    dispatch_dest_preg = d;  dispatch_rob_idx = r;   dispatch_payload = mkpay(r, d);
  endtask

  task automatic clear_in();
    dispatch_valid = 1'b0; dispatch_opa_ready = 1'b0; dispatch_opb_ready = 1'b0;
    dispatch_opa_preg = '0; dispatch_opb_preg = '0;
    dispatch_opa_value = '0; dispatch_opb_value = '0;
    dispatch_dest_preg = '0; dispatch_rob_idx = '0; dispatch_payload = '0;
    cdb_valid = 1'b0; cdb_preg = '0; cdb_value = '0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_preg = t; cdb_value = v;
  endtask

  initial begin
    reset = 1'b1; fu_busy = 1'b0; flush = 1'b0;
    clear_in();
    step(); step();
    reset = 1'b0;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_full", rs_full, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_rob", issue_rob_idx, 0);
    chk("rst_issue_opa", issue_opa_value, 0);
    chk("rst_issue_pay", issue_payload, 0);

    // Single ready op: resident for one cycle, issues at the second edge.
    set_op(1, 6'd1, 32'd5, 1, 6'd2, 32'd5, 6'd10, 5'd3);
    push_exp(32'd5, 32'd5, 6'd10, 5'd3);
    step(); clear_in();
    chk("t1_occ_after_disp", occupancy, 1);
    chk("t1_no_issue_e0", issue_valid, 0);
    step();
    chk("t1_issue_e1", issue_valid, 1);
    chk("t1_occ_after_issue", occupancy, 0);
    step();
    chk("t1_pulse_end", issue_valid, 0);

    // A waits on tag 7; younger ready B and C issue first.
    set_op(0, 6'd7, 32'h0, 1, 6'd3, 32'h21, 6'd11, 5'd4);
    step();
    set_op(1, 6'd4, 32'h30, 1, 6'd5, 32'h31, 6'd12, 5'd5);
    push_exp(32'h30, 32'h31, 6'd12, 5'd5);
    step();
    set_op(1, 6'd6, 32'h40, 1, 6'd8, 32'h41, 6'd13, 5'd6);
    push_exp(32'h40, 32'h41, 6'd13, 5'd6);
    step(); clear_in();
    chk("t2_b_issued", issue_valid, 1);
    step();
    chk("t2_c_issued", issue_valid, 1);
    step();
    chk("t2_idle", issue_valid, 0);
    cdb(6'd7, 32'h10);
    push_exp(32'h10, 32'h21, 6'd11, 5'd4);
    step(); clear_in();
    chk("t2_wake_no_issue", issue_valid, 0);
    step();
    chk("t2_a_issued", issue_valid, 1);
    step();
    chk("t2_occ_empty", occupancy, 0);

    // Fill with waiting ops; a fifth dispatch is dropped.
    for (int i = 0; i < 4; i++) begin
      set_op(0, 6'(20 + i), 32'h0, 1, 6'd1, 32'(i), 6'(30 + i), 5'(16 + i));
      step();
    end
    clear_in();
    chk("t3_full", rs_full, 1);
    chk("t3_occ4", occupancy, 4);
    set_op(1, 6'd1, 32'h99, 1, 6'd1, 32'h99, 6'd40, 5'd15);
    step(); clear_in();
    chk("t3_drop_occ", occupancy, 4);
    chk("t3_drop_full", rs_full, 1);
    for (int i = 0; i < 4; i++) begin
      cdb(6'(20 + i), 32'(32'h100 + i));
      push_exp(32'(32'h100 + i), 32'(i), 6'(30 + i), 5'(16 + i));
      step();
    end
    clear_in();
    step(); step();
    chk("t3_drained", occupancy, 0);
    chk("t3_not_full", rs_full, 0);

    // fu_busy blocks issue; release drains oldest first.
    fu_busy = 1'b1;
    set_op(1, 6'd1, 32'h50, 1, 6'd2, 32'h51, 6'd14, 5'd7);
    push_exp(32'h50, 32'h51, 6'd14, 5'd7);
    step();
    set_op(1, 6'd1, 32'h60, 1, 6'd2, 32'h61, 6'd15, 5'd8);
    push_exp(32'h60, 32'h61, 6'd15, 5'd8);
    step(); clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_busy_hold", issue_valid, 0);
    end
    fu_busy = 1'b0;
    step();
    chk("t4_first", issue_valid, 1);
    step();
    chk("t4_second", issue_valid, 1);
    step();
    chk("t4_done", issue_valid, 0);

    // Dispatch/CDB bypass on opb.
    set_op(1, 6'd1, 32'h70, 0, 6'd9, 32'h0, 6'd16, 5'd9);
    cdb(6'd9, 32'h44);
    push_exp(32'h70, 32'h44, 6'd16, 5'd9);
    step(); clear_in();
    step();
    chk("t5_bypass_issue", issue_valid, 1);

    // Duplicate tags on both operands wake together.
    set_op(0, 6'd11, 32'h0, 0, 6'd11, 32'h0, 6'd17, 5'd10);
    step(); clear_in();
    cdb(6'd11, 32'h77);
    push_exp(32'h77, 32'h77, 6'd17, 5'd10);
    step(); clear_in();
    step();
    chk("t5_dup_issue", issue_valid, 1);

    // Three waiting ops, unmatched CDB, then flush with a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      set_op(0, 6'(40 + i), 32'h0, 0, 6'(40 + i), 32'h0, 6'(50 + i), 5'(20 + i));
      step();
    end
    clear_in();
    cdb(6'd60, 32'hBAD);
    step(); clear_in();
    step();
    chk("t6_unmatched_occ", occupancy, 3);
    chk("t6_unmatched_noissue", issue_valid, 0);
    set_op(1, 6'd1, 32'h1, 1, 6'd1, 32'h1, 6'd55, 5'd25);
    flush = 1'b1;
    step();
    flush = 1'b0; clear_in();
    chk("t6_flush_occ", occupancy, 0);
    chk("t6_flush_issue", issue_valid, 0);
    chk("t6_flush_full", rs_full, 0);
    for (int i = 0; i < 3; i++) begin
      cdb(6'(40 + i), 32'h5);
      step();
    end
    clear_in();
    step(); step();
    chk("t6_still_empty", occupancy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_rs_scheduler.md
Name: branch_rs_scheduler

Overview:
- Reservation station and issue scheduler for the branch execution unit.
- Buffers dispatched branch/jump ops and captures operand values from the CDB as they are produced.
- Issues the oldest ready entry to the branch unit, one op per cycle, whenever the unit is free.
- Squashes all contents on a misprediction flush.

Parameters:
- RS_SIZE, 4, number of entries; power of two, minimum 2.
- XLEN, 32, operand width.
- PRF_LEN, 6, physical register index width.
- ROB_LEN, 5, ROB index width.
- PAY_W, 96, opaque payload width (PC, offset, cond_branch, prediction bits); carried unmodified.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- dispatch_valid  in  1  new op presented this cycle.
- dispatch_opa_ready  in  1  opa value valid at dispatch.
- dispatch_opa_preg  in  PRF_LEN  opa tag.
- dispatch_opa_value  in  XLEN  opa value (used when ready).
- dispatch_opb_ready  in  1  opb value valid at dispatch.
- dispatch_opb_preg  in  PRF_LEN  opb tag.
- dispatch_opb_value  in  XLEN  opb value (used when ready).
- dispatch_dest_preg  in  PRF_LEN  destination tag (link register).
- dispatch_rob_idx  in  ROB_LEN  ROB index.
- dispatch_payload  in  PAY_W  opaque payload.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_preg  in  PRF_LEN  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- fu_busy  in  1  branch unit holds an unbroadcast result; block issue.
- flush  in  1  mispredict squash.
- rs_full  out  1  no free entry.
- occupancy  out  $clog2(RS_SIZE)+1  valid entry count.
- issue_valid  out  1  issue packet valid (one-cycle pulse per op).
- issue_opa_value  out  XLEN  issued opa value.
- issue_opb_value  out  XLEN  issued opb value.
- issue_dest_preg  out  PRF_LEN  issued destination tag.
- issue_rob_idx  out  ROB_LEN  issued ROB index.
- issue_payload  out  PAY_W  issued payload.

Behaviour:
- Reset: all entries invalid; occupancy=0; rs_full=0; issue_valid=0; all issue data outputs 0.
- Entry state: valid, opa/opb ready+tag+value, dest, rob, payload, age (0 = oldest, values 0..occupancy-1, unique).
- Dispatch:
  - Accepted at the clock edge iff dispatch_valid && !rs_full && !flush.
  - Written into the lowest-index free entry with age = current occupancy minus the number of entries issued at that same edge.
  - Dispatch while rs_full is silently dropped, even if an issue frees a slot at the same edge. The dispatcher must not assert dispatch_valid while rs_full=1.
- Wakeup:
  - Each edge, any valid non-ready operand whose tag equals cdb_preg with cdb_valid=1 becomes ready and latches cdb_value.
  - The same match applies to a non-ready operand being dispatched at that edge (dispatch/CDB bypass).
- Select:
  - Combinational over registered state.
  - Candidate = valid entry with both operands ready; pick the candidate with the lowest age.
  - No issue when fu_busy=1.
- Issue:
  - On the edge where a candidate is selected and fu_busy=0 and flush=0, the issue_* registers load the entry and issue_valid becomes 1.
  - The entry is invalidated at the same edge; every entry with larger age decrements its age by 1.
  - At any edge with no issue, issue_valid returns to 0; issue data holds its last value.
- Latency: an op dispatched ready at edge E0 drives issue_valid=1 in the cycle after E1 (one cycle of residency). An operand woken at edge Ew makes its entry eligible for selection at Ew+1.
- Counts: occupancy and rs_full are registered; occupancy_next = occupancy + dispatched - issued.
- Flush: at the edge with flush=1, all entries are invalidated, occupancy=0 and issue_valid=0. Flush overrides same-edge dispatch, wakeup and issue. Reset has priority over flush.
- Boundaries:
  - Age order stays consistent through interleaved dispatch/issue; there is no counter wrap because ages are bounded by RS_SIZE.
  - Duplicate tags on opa/opb both wake on one broadcast.
  - A CDB tag matching no entry has no effect.

Test Plan:
- Reset, then dispatch one op with both operands ready (opa=5, opb=5, rob=3) -> issue_valid=1 exactly 2 edges after dispatch with rob_idx=3, opa=5; occupancy returns 1 -> 0.
- Dispatch A (opa tag 7, not ready), then B (ready), then C (ready) -> B issues, then C. CDB tag 7 value 0x10 -> A issues with opa=0x10 on the following cycle.
- Fill 4 entries with non-ready ops -> rs_full=1, occupancy=4. A 5th dispatch is dropped: no occupancy change, never issued.
- Hold fu_busy=1 with 2 ready entries for 3 cycles -> issue_valid stays 0. Release -> oldest issues first, then the next on consecutive cycles.
- Dispatch with opb tag 9 in the same cycle as CDB tag 9 value 0x44 -> entry captures 0x44 and issues with no further wakeup.
- 3 entries valid plus a same-cycle dispatch, flush=1 -> occupancy=0, issue_valid=0 next cycle. None of the 4 ops ever issues.
